// File: rtl/ram_arbiter_pkg.sv
// Shared types and constants for the SDRAM front-end arbiter and its picker.
package ram_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT_RD = 3'd2,
        DELIVER = 3'd3,
        RELEASE = 3'd4
    } arb_state_t;

    localparam int ARB_RR   = 0;
    localparam int ARB_PRIO = 1;

    typedef enum logic {
        CMD_WR = 1'b0,
        CMD_RD = 1'b1
    } cmd_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational request picker: round-robin after the last grant, or fixed
// priority with channel 0 highest. Emits a one-hot grant and its index.
module rr_picker #(
    parameter int NCH = 2,
    parameter int IW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] req,
    input  logic [IW-1:0]  last,
    input  logic           mode,
    output logic [NCH-1:0] gnt,
    output logic [IW-1:0]  idx
);
    import ram_arbiter_pkg::*;

    logic [IW-1:0] cand;
    logic          found;

    // Walk the candidates in the order the mode dictates; the first active one wins
    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (mode == 1'(ARB_PRIO)) begin
                cand = IW'(i);
            end else begin
                cand = IW'((int'(last) + i + 1) % NCH);
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// Multi-master front end for sdram_block: one downstream command at a time,
// read data is routed back to the channel that issued the read.
module ram_arbiter #(
    parameter int NCH  = 2,
    parameter int AW   = 24,
    parameter int DW   = 16,
    parameter int MODE = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCH-1:0][AW-1:0]  ch_addr,
    input  logic [NCH-1:0][DW-1:0]  ch_wr_data,
    input  logic [NCH-1:0]          ch_wr_en,
    input  logic [NCH-1:0]          ch_rd_en,
    output logic [NCH-1:0]          ch_gnt,
    output logic [DW-1:0]           ch_rd_data,
    output logic [NCH-1:0]          ch_rd_ready,
    input  logic [NCH-1:0]          ch_rd_ack,
    output logic [AW-1:0]           ram_addr,
    output logic [DW-1:0]           ram_wr_data,
    output logic                    ram_wr_en,
    output logic                    ram_rd_en,
    input  logic                    ram_busy,
    input  logic [DW-1:0]           ram_rd_data,
    input  logic                    ram_rd_ready,
    output logic                    ram_rd_ack
);
    import ram_arbiter_pkg::*;

    localparam int IW = $clog2(NCH);

    arb_state_t      state_q, state_d;
    cmd_t            cmd_q, cmd_d;
    logic [IW-1:0]   win_q, win_d;
    logic [IW-1:0]   last_q, last_d;

    logic [NCH-1:0]  ch_gnt_q, ch_gnt_d;
    logic [DW-1:0]   ch_rd_data_q, ch_rd_data_d;
    logic [NCH-1:0]  ch_rd_ready_q, ch_rd_ready_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_wr_data_q, ram_wr_data_d;
    logic            ram_wr_en_q, ram_wr_en_d;
    logic            ram_rd_en_q, ram_rd_en_d;
    logic            ram_rd_ack_q, ram_rd_ack_d;

    logic [NCH-1:0]  req;
    logic [NCH-1:0]  pick_gnt;
    logic [IW-1:0]   pick_idx;

    assign req = ch_wr_en | ch_rd_en;

    rr_picker #(
        .NCH (NCH),
        .IW  (IW)
    ) u_picker (
        .req  (req),
        .last (last_q),
        .mode (1'(MODE)),
        .gnt  (pick_gnt),
        .idx  (pick_idx)
    );

    // Next-state and registered-output logic; pulses default low, data outputs hold
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        win_d         = win_q;
        last_d        = last_q;
        ch_gnt_d      = '0;
        ch_rd_data_d  = ch_rd_data_q;
        ch_rd_ready_d = ch_rd_ready_q;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        ram_wr_en_d   = 1'b0;
        ram_rd_en_d   = 1'b0;
        ram_rd_ack_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if ((|req) && !ram_busy) begin
                    win_d         = pick_idx;
                    last_d        = pick_idx;
                    cmd_d         = ch_wr_en[pick_idx] ? CMD_WR : CMD_RD;
                    ram_addr_d    = ch_addr[pick_idx];
                    ram_wr_data_d = ch_wr_data[pick_idx];
                    ram_wr_en_d   = ch_wr_en[pick_idx];
                    ram_rd_en_d   = !ch_wr_en[pick_idx];
                    ch_gnt_d      = pick_gnt;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                state_d = (cmd_q == CMD_WR) ? IDLE : WAIT_RD;
            end
            WAIT_RD: begin
                if (ram_rd_ready) begin
                    ch_rd_data_d         = ram_rd_data;
                    ch_rd_ready_d        = '0;
                    ch_rd_ready_d[win_q] = 1'b1;
                    state_d              = DELIVER;
                end
            end
            DELIVER: begin
                if (ch_rd_ack[win_q]) begin
                    ch_rd_ready_d = '0;
                    ram_rd_ack_d  = 1'b1;
                    state_d       = RELEASE;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            cmd_q         <= CMD_WR;
            win_q         <= '0;
            last_q        <= IW'(NCH - 1);
            ch_gnt_q      <= '0;
            ch_rd_data_q  <= '0;
            ch_rd_ready_q <= '0;
            ram_addr_q    <= '0;
            ram_wr_data_q <= '0;
            ram_wr_en_q   <= 1'b0;
            ram_rd_en_q   <= 1'b0;
            ram_rd_ack_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd_q         <= cmd_d;
            win_q         <= win_d;
            last_q        <= last_d;
            ch_gnt_q      <= ch_gnt_d;
            ch_rd_data_q  <= ch_rd_data_d;
            ch_rd_ready_q <= ch_rd_ready_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_rd_en_q   <= ram_rd_en_d;
            ram_rd_ack_q  <= ram_rd_ack_d;
        end
    end

    assign ch_gnt      = ch_gnt_q;
    assign ch_rd_data  = ch_rd_data_q;
    assign ch_rd_ready = ch_rd_ready_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_wr_en   = ram_wr_en_q;
    assign ram_rd_en   = ram_rd_en_q;
    assign ram_rd_ack  = ram_rd_ack_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a round-robin instance and a fixed-priority instance,
// both with three channels, checked against a transaction-level reference.
module tb_ram_arbiter;

    localparam int NCH = 3;
    localparam int AW  = 24;
    localparam int DW  = 16;

    logic                   clk;
    logic                   rst;
    logic [NCH-1:0][AW-1:0] ch_addr;
    logic [NCH-1:0][DW-1:0] ch_wr_data;
    logic [1:0][NCH-1:0]    wr_en;
    logic [1:0][NCH-1:0]    rd_en;
    logic [1:0][NCH-1:0]    hold_req;
    logic [NCH-1:0]         ch_rd_ack;
    logic                   ram_busy;
    logic [DW-1:0]          ram_rd_data;
    logic                   ram_rd_ready;

    logic [1:0][NCH-1:0]    o_gnt;
    logic [1:0][NCH-1:0]    o_rdy;
    logic [1:0][DW-1:0]     o_rdata;
    logic [1:0][AW-1:0]     o_addr;
    logic [1:0][DW-1:0]     o_wdata;
    logic [1:0]             o_wen;
    logic [1:0]             o_ren;
    logic [1:0]             o_ack;

    logic [NCH-1:0] e_gnt   [2];
    logic [NCH-1:0] e_rdy   [2];
    logic [DW-1:0]  e_rdata [2];
    logic [AW-1:0]  e_addr  [2];
    logic [DW-1:0]  e_wdata [2];
    logic           e_wen   [2];
    logic           e_ren   [2];
    logic           e_ack   [2];
    int             e_cool  [2];
    int             e_pend  [2];
    int             e_dlv   [2];
    int             e_last  [2];

    int checks;
    int failures;
    int cycle;

    ram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(0)) dut_rr (
        .clk          (clk),
        .rst          (rst),
        .ch_addr      (ch_addr),
        .ch_wr_data   (ch_wr_data),
        .ch_wr_en     (wr_en[0]),
        .ch_rd_en     (rd_en[0]),
        .ch_gnt       (o_gnt[0]),
        .ch_rd_data   (o_rdata[0]),
        .ch_rd_ready  (o_rdy[0]),
        .ch_rd_ack    (ch_rd_ack),
        .ram_addr     (o_addr[0]),
        .ram_wr_data  (o_wdata[0]),
        .ram_wr_en    (o_wen[0]),
        .ram_rd_en    (o_ren[0]),
        .ram_busy     (ram_busy),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_ready (ram_rd_ready),
        .ram_rd_ack   (o_ack[0])
    );

    ram_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .MODE(1)) dut_prio (
        .clk          (clk),
        .rst          (rst),
        .ch_addr      (ch_addr),
        .ch_wr_data   (ch_wr_data),
        .ch_wr_en     (wr_en[1]),
        .ch_rd_en     (rd_en[1]),
        .ch_gnt       (o_gnt[1]),
        .ch_rd_data   (o_rdata[1]),
        .ch_rd_ready  (o_rdy[1]),
        .ch_rd_ack    (ch_rd_ack),
        .ram_addr     (o_addr[1]),
        .ram_wr_data  (o_wdata[1]),
        .ram_wr_en    (o_wen[1]),
        .ram_rd_en    (o_ren[1]),
        .ram_busy     (ram_busy),
        .ram_rd_data  (ram_rd_data),
        .ram_rd_ready (ram_rd_ready),
        .ram_rd_ack   (o_ack[1])
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Winner rule: instance 0 scans from the channel after the last grant, instance 1 from channel 0
    function automatic int pickWinner(input logic [NCH-1:0] req, input int last, input int prio);
        int c;
        for (int k = 0; k < NCH; k++) begin
            c = prio ? k : (last + 1 + k) % NCH;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // Reference: an owner/countdown view of the arbiter, advanced on each rising edge
    always @(posedge clk) begin : ref_model
        int w;
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                e_gnt[d]   <= '0;
                e_rdy[d]   <= '0;
                e_rdata[d] <= '0;
                e_addr[d]  <= '0;
                e_wdata[d] <= '0;
                e_wen[d]   <= 1'b0;
                e_ren[d]   <= 1'b0;
                e_ack[d]   <= 1'b0;
                e_cool[d]  <= 0;
                e_pend[d]  <= -1;
                e_dlv[d]   <= -1;
                e_last[d]  <= NCH - 1;
            end else begin
                e_gnt[d] <= '0;
                e_wen[d] <= 1'b0;
                e_ren[d] <= 1'b0;
                e_ack[d] <= 1'b0;
                if (e_cool[d] > 0) begin
                    e_cool[d] <= e_cool[d] - 1;
                end else if (e_pend[d] >= 0) begin
                    if (ram_rd_ready) begin
                        e_rdata[d] <= ram_rd_data;
                        e_rdy[d]   <= NCH'(1) << e_pend[d];
                        e_dlv[d]   <= e_pend[d];
                        e_pend[d]  <= -1;
                    end
                end else if (e_dlv[d] >= 0) begin
                    if (ch_rd_ack[e_dlv[d]]) begin
                        e_rdy[d]  <= '0;
                        e_ack[d]  <= 1'b1;
                        e_dlv[d]  <= -1;
                        e_cool[d] <= 1;
                    end
                end else begin
                    w = pickWinner(wr_en[d] | rd_en[d], e_last[d], d);
                    if (w >= 0 && !ram_busy) begin
                        e_gnt[d]   <= NCH'(1) << w;
                        e_addr[d]  <= ch_addr[w];
                        e_wdata[d] <= ch_wr_data[w];
                        e_last[d]  <= w;
                        e_cool[d]  <= 1;
                        if (wr_en[d][w]) begin
                            e_wen[d] <= 1'b1;
                        end else begin
                            e_ren[d] <= 1'b1;
                            e_pend[d] <= w;
                        end
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s cycle %0d: actual=%0h expected=%0h", name, cycle, actual, expected);
        end
    endtask

    task automatic cmpModel(input string name, input int d, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL model_%s dut%0d cycle %0d: actual=%0h expected=%0h", name, d, cycle, actual, expected);
        end
    endtask

    task automatic compareModel();
        for (int d = 0; d < 2; d++) begin
            cmpModel("gnt",   d, 32'(o_gnt[d]),   32'(e_gnt[d]));
            cmpModel("rdy",   d, 32'(o_rdy[d]),   32'(e_rdy[d]));
            cmpModel("rdata", d, 32'(o_rdata[d]), 32'(e_rdata[d]));
            cmpModel("addr",  d, 32'(o_addr[d]),  32'(e_addr[d]));
            cmpModel("wdata", d, 32'(o_wdata[d]), 32'(e_wdata[d]));
            cmpModel("wen",   d, 32'(o_wen[d]),   32'(e_wen[d]));
            cmpModel("ren",   d, 32'(o_ren[d]),   32'(e_ren[d]));
            cmpModel("ack",   d, 32'(o_ack[d]),   32'(e_ack[d]));
        end
    endtask

    // One cycle: compare on the falling edge, then masters and the memory react to what they saw
    task automatic applyStimulus();
        @(negedge clk);
        cycle++;
        compareModel();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NCH; i++) begin
                if (!hold_req[d][i] && o_gnt[d][i]) begin
                    if (wr_en[d][i]) wr_en[d][i] = 1'b0;
                    else             rd_en[d][i] = 1'b0;
                end
            end
        end
        if (o_ack[0]) ram_rd_ready = 1'b0;
    endtask

    function automatic int oneHotIdx(input logic [NCH-1:0] v);
        for (int i = 0; i < NCH; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic checkAllZero(input string name);
        checkOutput({name, "_gnt"},   32'(o_gnt[0]),   0);
        checkOutput({name, "_rdy"},   32'(o_rdy[0]),   0);
        checkOutput({name, "_rdata"}, 32'(o_rdata[0]), 0);
        checkOutput({name, "_addr"},  32'(o_addr[0]),  0);
        checkOutput({name, "_wdata"}, 32'(o_wdata[0]), 0);
        checkOutput({name, "_wen"},   32'(o_wen[0]),   0);
        checkOutput({name, "_ren"},   32'(o_ren[0]),   0);
        checkOutput({name, "_ack"},   32'(o_ack[0]),   0);
    endtask

    // Full read on the round-robin instance; optionally a write arrives during the ack cycle
    task automatic doRead(input int ch, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int extra_ch);
        ch_addr[ch]   = addr;
        rd_en[0][ch]  = 1'b1;
        applyStimulus();
        checkOutput("rd_gnt",   32'(o_gnt[0]), 32'(1) << ch);
        checkOutput("rd_pulse", 32'(o_ren[0]), 1);
        checkOutput("rd_wen",   32'(o_wen[0]), 0);
        checkOutput("rd_addr",  32'(o_addr[0]), 32'(addr));
        applyStimulus();
        applyStimulus();
        ram_rd_data  = data;
        ram_rd_ready = 1'b1;
        applyStimulus();
        checkOutput("rd_ready", 32'(o_rdy[0]), 32'(1) << ch);
        checkOutput("rd_data",  32'(o_rdata[0]), 32'(data));
        ch_rd_ack = '0;
        ch_rd_ack[(ch + 1) % NCH] = 1'b1;
        applyStimulus();
        checkOutput("rd_other_ack_ignored", 32'(o_rdy[0]), 32'(1) << ch);
        checkOutput("rd_no_early_release",  32'(o_ack[0]), 0);
        ch_rd_ack = '0;
        ch_rd_ack[ch] = 1'b1;
        if (extra_ch >= 0) begin
            ch_addr[extra_ch]    = 24'h00E000 + AW'(extra_ch);
            ch_wr_data[extra_ch] = 16'h7000 + DW'(extra_ch);
            wr_en[0][extra_ch]   = 1'b1;
        end
        applyStimulus();
        ch_rd_ack = '0;
        checkOutput("rd_ready_drop", 32'(o_rdy[0]), 0);
        checkOutput("ram_rd_ack",    32'(o_ack[0]), 1);
        applyStimulus();
        checkOutput("ram_rd_ack_single", 32'(o_ack[0]), 0);
        checkOutput("no_gnt_m2",         32'(o_gnt[0]), 0);
        if (extra_ch >= 0) begin
            applyStimulus();
            checkOutput("gnt_m3", 32'(o_gnt[0]), 32'(1) << extra_ch);
            checkOutput("wen_m3", 32'(o_wen[0]), 1);
        end
    endtask

    // Directed scenario sequence
    initial begin
        int gch[$];
        int gcy[$];
        checks       = 0;
        failures     = 0;
        cycle        = 0;
        rst          = 1'b0;
        ch_addr      = '0;
        ch_wr_data   = '0;
        wr_en        = '0;
        rd_en        = '0;
        hold_req     = '0;
        ch_rd_ack    = '0;
        ram_busy     = 1'b0;
        ram_rd_data  = '0;
        ram_rd_ready = 1'b0;

        repeat (3) applyStimulus();
        checkAllZero("reset");
        rst = 1'b1;
        repeat (2) applyStimulus();

        // Single write on channel 0
        ch_addr[0]    = 24'h000123;
        ch_wr_data[0] = 16'hBEEF;
        wr_en[0][0]   = 1'b1;
        applyStimulus();
        checkOutput("wr_gnt",   32'(o_gnt[0]),   32'h1);
        checkOutput("wr_pulse", 32'(o_wen[0]),   1);
        checkOutput("wr_ren",   32'(o_ren[0]),   0);
        checkOutput("wr_addr",  32'(o_addr[0]),  32'h000123);
        checkOutput("wr_data",  32'(o_wdata[0]), 32'hBEEF);
        applyStimulus();
        checkOutput("wr_done_gnt", 32'(o_gnt[0]), 0);
        checkOutput("wr_done_wen", 32'(o_wen[0]), 0);
        applyStimulus();

        // Single read on channel 1, with a channel 2 write arriving during delivery
        doRead(1, 24'h00ABCD, 16'h1234, 2);
        repeat (2) applyStimulus();

        // Channel 0 with write and read both set: write first, read in a later round
        ch_addr[0]    = 24'h000050;
        ch_wr_data[0] = 16'hA5A5;
        wr_en[0][0]   = 1'b1;
        rd_en[0][0]   = 1'b1;
        applyStimulus();
        checkOutput("both_wr_first", 32'(o_wen[0]), 1);
        checkOutput("both_no_rd",    32'(o_ren[0]), 0);
        applyStimulus();
        applyStimulus();
        checkOutput("both_rd_later", 32'(o_ren[0]), 1);
        checkOutput("both_rd_gnt",   32'(o_gnt[0]), 32'h1);
        ram_rd_data  = 16'h0F0F;
        ram_rd_ready = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("both_rd_data", 32'(o_rdata[0]), 32'h0F0F);
        ch_rd_ack[0] = 1'b1;
        applyStimulus();
        ch_rd_ack = '0;
        repeat (2) applyStimulus();

        // Reset restores the pointer so channel 0 wins first; continuous writes rotate 0,1,2
        rst = 1'b0;
        applyStimulus();
        rst = 1'b1;
        applyStimulus();
        for (int i = 0; i < NCH; i++) begin
            ch_addr[i]    = 24'h001000 + AW'(i);
            ch_wr_data[i] = 16'h1100 + DW'(i);
        end
        hold_req[0] = '1;
        wr_en[0]    = '1;
        repeat (12) begin
            applyStimulus();
            if (o_gnt[0] != '0) begin
                gch.push_back(oneHotIdx(o_gnt[0]));
                gcy.push_back(cycle);
            end
        end
        wr_en[0]    = '0;
        hold_req[0] = '0;
        checkOutput("rr_count", 32'(gch.size()), 6);
        for (int k = 0; k < 6; k++) begin
            checkOutput("rr_order", (k < gch.size()) ? 32'(gch[k]) : 32'hFFFFFFFF, 32'(k % 3));
        end
        for (int k = 1; k < 6; k++) begin
            checkOutput("rr_spacing", (k < gcy.size()) ? 32'(gcy[k] - gcy[k-1]) : 32'hFFFFFFFF, 2);
        end
        repeat (2) applyStimulus();

        // Fixed priority: channel 0 starves channel 2 until it drops out
        gch.delete();
        hold_req[1] = 3'b101;
        wr_en[1]    = 3'b101;
        repeat (8) begin
            applyStimulus();
            if (o_gnt[1] != '0) gch.push_back(oneHotIdx(o_gnt[1]));
        end
        checkOutput("prio_count", 32'(gch.size()), 4);
        for (int k = 0; k < 4; k++) begin
            checkOutput("prio_ch0_only", (k < gch.size()) ? 32'(gch[k]) : 32'hFFFFFFFF, 0);
        end
        wr_en[1][0] = 1'b0;
        hold_req[1] = '0;
        applyStimulus();
        checkOutput("prio_ch2_after_drop", 32'(o_gnt[1]), 32'h4);
        repeat (2) applyStimulus();

        // Busy holds off a pending request; grant follows the cycle busy falls
        ch_addr[0]    = 24'h00BB00;
        ch_wr_data[0] = 16'h0B0B;
        wr_en[0][0]   = 1'b1;
        ram_busy      = 1'b1;
        repeat (5) begin
            applyStimulus();
            checkOutput("busy_no_gnt", 32'(o_gnt[0]), 0);
            checkOutput("busy_no_wen", 32'(o_wen[0]), 0);
        end
        ram_busy = 1'b0;
        applyStimulus();
        checkOutput("busy_release_gnt", 32'(o_gnt[0]), 32'h1);
        checkOutput("busy_release_wen", 32'(o_wen[0]), 1);
        repeat (2) applyStimulus();

        // Reset while delivering read data, then a clean read on channel 1
        ch_addr[1]  = 24'h000456;
        rd_en[0][1] = 1'b1;
        applyStimulus();
        applyStimulus();
        ram_rd_data  = 16'hC0DE;
        ram_rd_ready = 1'b1;
        applyStimulus();
        checkOutput("pre_reset_ready", 32'(o_rdy[0]), 32'h2);
        rst          = 1'b0;
        ram_rd_ready = 1'b0;
        applyStimulus();
        checkAllZero("deliver_reset");
        rst = 1'b1;
        repeat (3) begin
            applyStimulus();
            checkOutput("no_ack_after_reset", 32'(o_ack[0]), 0);
        end
        doRead(1, 24'h000777, 16'h5A5A, -1);
        repeat (2) applyStimulus();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
